// File: rtl/barrel_seq_pkg.sv
// Shared definitions for the barrel rotator and its command sequencer:
// default widths and the sequencer state encoding.
package barrel_seq_pkg;

  localparam int unsigned DefDataSize = 8;
  localparam int unsigned DefSelW     = 3;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StLoad    = 3'd1,
    StRotate  = 3'd2,
    StCapture = 3'd3,
    StDone    = 3'd4
  } seq_state_e;

endpackage

// File: rtl/barrel.sv
// Registered left rotator: each edge rotates either Data_in (on Load) or the
// current output left by Select+1 positions.
module barrel
  import barrel_seq_pkg::*;
#(
  parameter int unsigned DATA_SIZE = DefDataSize,
  parameter int unsigned SEL_W     = DefSelW
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 Load,
  input  logic [SEL_W-1:0]     Select,
  input  logic [DATA_SIZE-1:0] Data_in,
  output logic [DATA_SIZE-1:0] Data_out
);

  logic [DATA_SIZE-1:0]   src;
  logic [DATA_SIZE-1:0]   rot;
  logic [2*DATA_SIZE-1:0] dbl;
  logic [31:0]            amt;

  // Shift a doubled word so the upper half holds the rotated value.
  always_comb begin
    src = Load ? Data_in : Data_out;
    amt = (32'(Select) + 32'd1) % DATA_SIZE;
    dbl = {src, src} << amt;
    rot = dbl[2*DATA_SIZE-1:DATA_SIZE];
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      Data_out <= '0;
    end else begin
      Data_out <= rot;
    end
  end

endmodule

// File: rtl/barrel_seq.sv
// Command sequencer for the barrel rotator: loads a word once, lets the
// barrel free-rotate for the requested steps, then returns the result.
module barrel_seq
  import barrel_seq_pkg::*;
#(
  parameter int unsigned DATA_SIZE = DefDataSize,
  parameter int unsigned SEL_W     = DefSelW,
  parameter int unsigned STEP_W    = 4,
  parameter int unsigned CNT_W     = 8
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [DATA_SIZE-1:0] cmd_data,
  input  logic [SEL_W-1:0]     cmd_sel,
  input  logic [STEP_W-1:0]    cmd_steps,
  output logic                 br_load,
  output logic [SEL_W-1:0]     br_select,
  output logic [DATA_SIZE-1:0] br_data,
  input  logic [DATA_SIZE-1:0] br_q,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [DATA_SIZE-1:0] res_data,
  output logic                 busy,
  output logic [CNT_W-1:0]     done_count
);

  seq_state_e           state_q;
  logic [DATA_SIZE-1:0] data_q;
  logic [SEL_W-1:0]     sel_q;
  logic [STEP_W-1:0]    cnt_q;
  logic [DATA_SIZE-1:0] res_q;
  logic [CNT_W-1:0]     done_q;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= StIdle;
      data_q  <= '0;
      sel_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      done_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // Command fields are only sampled here, so X while idle never lands.
          if (cmd_valid) begin
            data_q  <= cmd_data;
            sel_q   <= cmd_sel;
            cnt_q   <= cmd_steps;
            state_q <= StLoad;
          end
        end
        StLoad: begin
          state_q <= (cnt_q != '0) ? StRotate : StCapture;
        end
        StRotate: begin
          cnt_q <= cnt_q - STEP_W'(1);
          if (cnt_q == STEP_W'(1)) begin
            state_q <= StCapture;
          end
        end
        StCapture: begin
          res_q   <= br_q;
          state_q <= StDone;
        end
        StDone: begin
          if (res_ready) begin
            done_q  <= done_q + CNT_W'(1);
            state_q <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign cmd_ready  = (state_q == StIdle);
  assign br_load    = (state_q == StLoad);
  assign br_select  = sel_q;
  assign br_data    = data_q;
  assign res_valid  = (state_q == StDone);
  assign res_data   = res_q;
  assign busy       = (state_q != StIdle);
  assign done_count = done_q;

endmodule

// File: tb/tb_barrel_seq.sv
// Directed and randomized bench for barrel_seq driving a real barrel instance.
module tb_barrel_seq;

  localparam int unsigned DW  = 8;
  localparam int unsigned SW  = 3;
  localparam int unsigned STW = 4;
  localparam int unsigned CW  = 8;

  logic          Clock;
  logic          Reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [DW-1:0] cmd_data;
  logic [SW-1:0] cmd_sel;
  logic [STW-1:0] cmd_steps;
  logic          br_load;
  logic [SW-1:0] br_select;
  logic [DW-1:0] br_data;
  logic [DW-1:0] br_q;
  logic          res_valid;
  logic          res_ready;
  logic [DW-1:0] res_data;
  logic          busy;
  logic [CW-1:0] done_count;

  int checks   = 0;
  int failures = 0;
  int exp_count = 0;

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  barrel_seq #(
    .DATA_SIZE(DW),
    .SEL_W    (SW),
    .STEP_W   (STW),
    .CNT_W    (CW)
  ) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_data  (cmd_data),
    .cmd_sel   (cmd_sel),
    .cmd_steps (cmd_steps),
    .br_load   (br_load),
    .br_select (br_select),
    .br_data   (br_data),
    .br_q      (br_q),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .busy      (busy),
    .done_count(done_count)
  );

  barrel #(
    .DATA_SIZE(DW),
    .SEL_W    (SW)
  ) u_barrel (
    .Clock   (Clock),
    .Reset   (Reset),
    .Load    (br_load),
    .Select  (br_select),
    .Data_in (br_data),
    .Data_out(br_q)
  );

  function automatic logic [7:0] rotl_ref(input logic [7:0] d, input int n);
    logic [15:0] w;
    w = {d, d} << (n % 8);
    return w[15:8];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_br_load", 32'(br_load), 32'd0);
    check("rst_br_select", 32'(br_select), 32'd0);
    check("rst_br_data", 32'(br_data), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_data", 32'(res_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done_count", 32'(done_count), 32'd0);
  endtask

  // Called at a negedge while idle; returns at a negedge, idle if res_ready was
  // high, otherwise sitting in DONE.
  task automatic run_cmd(input logic [7:0] d, input logic [2:0] s, input logic [3:0] st);
    logic [7:0] exp;
    int k;
    int loads;
    exp = rotl_ref(d, (int'(st) + 1) * (int'(s) + 1));
    check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_data  = d;
    cmd_sel   = s;
    cmd_steps = st;
    @(negedge Clock);
    cmd_valid = 1'b0;
    cmd_data  = 8'($urandom);
    cmd_sel   = 3'($urandom);
    cmd_steps = 4'($urandom);
    check("load_data", 32'(br_data), 32'(d));
    check("load_select", 32'(br_select), 32'(s));
    check("cmd_ready_busy", 32'(cmd_ready), 32'd0);
    k = 1;
    loads = 0;
    while (res_valid !== 1'b1 && k < int'(st) + 12) begin
      loads += int'(br_load);
      @(negedge Clock);
      k++;
    end
    check("latency", 32'(k), 32'(int'(st) + 3));
    check("load_pulses", 32'(loads), 32'd1);
    check("res_data", 32'(res_data), 32'(exp));
    if (res_ready) begin
      exp_count = (exp_count + 1) % 256;
      @(negedge Clock);
      check("done_count", 32'(done_count), 32'(exp_count));
      check("idle_after", 32'(cmd_ready), 32'd1);
    end
  endtask

  initial begin
    logic [7:0] held;
    Reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_data  = '0;
    cmd_sel   = '0;
    cmd_steps = '0;
    res_ready = 1'b1;
    #2 Reset = 1'b0;
    #1 check_reset_outputs();
    repeat (2) @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);

    run_cmd(8'h81, 3'd0, 4'd0);
    check("tp1_result", 32'(res_data), 32'h03);
    run_cmd(8'h01, 3'd2, 4'd2);
    check("tp2_result", 32'(res_data), 32'h02);
    run_cmd(8'hA5, 3'd7, 4'd3);
    check("tp3_result", 32'(res_data), 32'hA5);

    // Backpressure: hold DONE, poke cmd_valid, then release.
    res_ready = 1'b0;
    run_cmd(8'h3C, 3'd1, 4'd1);
    held = rotl_ref(8'h3C, 4);
    for (int i = 0; i < 6; i++) begin
      cmd_valid = (i == 2);
      cmd_data  = 8'hFF;
      @(negedge Clock);
      check("bp_res_valid", 32'(res_valid), 32'd1);
      check("bp_res_data", 32'(res_data), 32'(held));
      check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    @(negedge Clock);
    exp_count = (exp_count + 1) % 256;
    check("bp_idle", 32'(cmd_ready), 32'd1);
    check("bp_not_busy", 32'(busy), 32'd0);
    check("bp_done_count", 32'(done_count), 32'(exp_count));

    // Reset while rotating.
    cmd_valid = 1'b1;
    cmd_data  = 8'h5A;
    cmd_sel   = 3'd3;
    cmd_steps = 4'd10;
    @(negedge Clock);
    cmd_valid = 1'b0;
    repeat (3) @(negedge Clock);
    check("mid_rotate_busy", 32'(busy), 32'd1);
    Reset = 1'b0;
    #1 check_reset_outputs();
    exp_count = 0;
    @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    run_cmd(8'hC3, 3'd4, 4'd5);

    // Clear the counter, then 256 back-to-back random commands must wrap it.
    Reset = 1'b0;
    #1 check("pre_rand_count", 32'(done_count), 32'd0);
    exp_count = 0;
    @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    for (int n = 0; n < 256; n++) begin
      run_cmd(8'($urandom), 3'($urandom), 4'($urandom));
    end
    check("wrap_count", 32'(done_count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
